// File: rtl/regfile_pkg.sv
// Shared constants and round-robin pick helper for the regfile writeback path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package regfile_pkg;

   localparam int AW      = 5;
   localparam int DW      = 32;
   localparam int MAX_REQ = 8;
   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   // One-hot grant: the first set bit of valid_mask at or above ptr,
   // wrapping from n-1 back to 0. Bits at or above n are ignored.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_mask,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
      logic [MAX_REQ-1:0] onehot;
      logic               found;
      int                 idx;
      onehot = '0;
      found  = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (!found && valid_mask[idx[2:0]]) begin
               onehot[idx[2:0]] = 1'b1;
               found            = 1'b1;
            end
         end
      end
      return onehot;
   endfunction

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry writeback buffer holding a single pending (rd, data) for one source.
// Latency: accepted at edge k, visible as buf_valid after edge k; refills in the cycle it is granted.
// Backpressure: in_ready = !buf_valid | grant, forced low during flush.
//
// Ports: clk/rst_n; flush clears the entry; in_valid/in_rd/in_data + in_ready form the
// source handshake; grant pops the entry; buf_valid/buf_rd/buf_data expose the entry.
module wb_skid_buf #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          grant,
   input  logic [AW-1:0] in_rd,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          buf_valid,
   output logic [AW-1:0] buf_rd,
   output logic [DW-1:0] buf_data
);

   assign in_ready = !flush && (!buf_valid || grant);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 1'b0;
         buf_rd    <= '0;
         buf_data  <= '0;
      end else if (flush) begin
         buf_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         // Covers both an empty buffer and a same-cycle pop/refill.
         buf_valid <= 1'b1;
         buf_rd    <= in_rd;
         buf_data  <= in_data;
      end else if (grant) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one regfile write port between NREQ writeback sources.
// Latency: accept at edge k -> regwr/rw/busW valid after edge k+1; regfile commits on the following falling edge.
// Backpressure: per-source one-entry buffer; in_ready low while that buffer waits, and during flush.
//
// Ports: clk/rst_n; flush drops all buffered writes; en=0 freezes grants; in_valid/in_ready/
// in_rd/in_data are the packed per-source requests; buf_valid exposes occupancy for hazard
// checks; regwr/rw/busW is the registered regfile write port (x0 writes are suppressed).
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = regfile_pkg::AW,
   parameter int DW   = regfile_pkg::DW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               en,
   input  logic [NREQ-1:0]    in_valid,
   output logic [NREQ-1:0]    in_ready,
   input  logic [NREQ*AW-1:0] in_rd,
   input  logic [NREQ*DW-1:0] in_data,
   output logic [NREQ-1:0]    buf_valid,
   output logic               regwr,
   output logic [AW-1:0]      rw,
   output logic [DW-1:0]      busW
);

   logic [AW-1:0]      buf_rd   [NREQ];
   logic [DW-1:0]      buf_data [NREQ];
   logic [NREQ-1:0]    grant;
   logic [2:0]         rr_ptr;
   logic [MAX_REQ-1:0] vmask;
   logic [MAX_REQ-1:0] pick;
   logic               gnt_any;
   logic [2:0]         gnt_idx;
   logic [AW-1:0]      sel_rd;
   logic [DW-1:0]      sel_data;

   for (genvar i = 0; i < NREQ; i++) begin : g_buf
      wb_skid_buf #(.AW(AW), .DW(DW)) u_buf (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .in_valid  (in_valid[i]),
         .grant     (grant[i]),
         .in_rd     (in_rd[i*AW +: AW]),
         .in_data   (in_data[i*DW +: DW]),
         .in_ready  (in_ready[i]),
         .buf_valid (buf_valid[i]),
         .buf_rd    (buf_rd[i]),
         .buf_data  (buf_data[i])
      );
   end

   always_comb begin
      vmask              = '0;
      vmask[NREQ-1:0]    = buf_valid;
      pick               = rr_pick(vmask, rr_ptr, NREQ);
      gnt_any            = en && !flush && (|pick);
      gnt_idx            = 3'd0;
      grant              = '0;
      sel_rd             = '0;
      sel_data           = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (pick[i]) gnt_idx = 3'(i);
      end
      // pick is one-hot, so an OR-mux selects the granted entry.
      for (int i = 0; i < NREQ; i++) begin
         grant[i] = gnt_any && pick[i];
         if (grant[i]) begin
            sel_rd   = sel_rd   | buf_rd[i];
            sel_data = sel_data | buf_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 3'd0;
         regwr  <= 1'b0;
         rw     <= '0;
         busW   <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
         rw     <= sel_rd;
         busW   <= sel_data;
         // An x0 write still consumes its slot but never strobes the regfile.
         regwr  <= (sel_rd != AW'(REG_ZERO));
      end else begin
         regwr  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               en;
   logic [NREQ-1:0]    in_valid;
   logic [NREQ-1:0]    in_ready;
   logic [NREQ*AW-1:0] in_rd;
   logic [NREQ*DW-1:0] in_data;
   logic [NREQ-1:0]    buf_valid;
   logic               regwr;
   logic [AW-1:0]      rw;
   logic [DW-1:0]      busW;

   logic [AW-1:0] src_rd   [NREQ];
   logic [DW-1:0] src_data [NREQ];

   logic [DW-1:0] rf [32];
   logic [AW+DW-1:0] exp_q [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign in_rd   = {src_rd[2], src_rd[1], src_rd[0]};
   assign in_data = {src_data[2], src_data[1], src_data[0]};

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .en        (en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .buf_valid (buf_valid),
      .regwr     (regwr),
      .rw        (rw),
      .busW      (busW)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Regfile model commits on the falling edge; the scoreboard pops here too.
   always @(negedge clk) begin
      if (rst_n && regwr) begin
         if (exp_q.size() == 0) begin
            chk("spurious_wr", {27'd0, rw, busW}, 64'd0);
         end else begin
            chk("wr_order", {27'd0, rw, busW}, {27'd0, exp_q.pop_front()});
         end
         if (rw != 0) rf[rw] = busW;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int s, input logic [AW-1:0] rd, input logic [DW-1:0] data);
      in_valid[s] = 1'b1;
      src_rd[s]   = rd;
      src_data[s] = data;
   endtask

   task automatic expect_wr(input logic [AW-1:0] rd, input logic [DW-1:0] data);
      if (rd != 0) exp_q.push_back({rd, data});
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = '0;
      flush    = 1'b0;
      en       = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      for (int i = 0; i < NREQ; i++) begin
         src_rd[i]   = '0;
         src_data[i] = '0;
      end
      in_valid = '0;
      flush    = 1'b0;
      en       = 1'b1;
      rst_n    = 1'b0;
      #2;
      chk("rst_regwr", regwr, 0);
      chk("rst_rw", rw, 0);
      chk("rst_busW", busW, 0);
      chk("rst_buf_valid", buf_valid, 0);
      chk("rst_in_ready", in_ready, 3'b111);
      do_reset();

      // 1: single write from src0
      drive(0, 5'd5, 32'hDEADBEEF);
      expect_wr(5'd5, 32'hDEADBEEF);
      chk("t1_ready", in_ready[0], 1);
      step();
      in_valid = '0;
      chk("t1_buf", buf_valid, 3'b001);
      chk("t1_regwr_early", regwr, 0);
      step();
      chk("t1_regwr", regwr, 1);
      chk("t1_rw", rw, 5);
      chk("t1_busW", busW, 32'hDEADBEEF);
      @(negedge clk);
      #1;
      chk("t1_rf5", rf[5], 32'hDEADBEEF);

      // 2: all three at once from rr_ptr=0
      do_reset();
      for (int s = 0; s < NREQ; s++) begin
         drive(s, 5'(s + 1), 32'h1000 + s);
         expect_wr(5'(s + 1), 32'h1000 + s);
      end
      step();
      in_valid = '0;
      chk("t2_buf0", buf_valid, 3'b111);
      step();
      chk("t2_rw_a", rw, 1);
      chk("t2_ready_a", in_ready, 3'b011);
      step();
      chk("t2_rw_b", rw, 2);
      chk("t2_ready_b", in_ready, 3'b111);
      step();
      chk("t2_rw_c", rw, 3);
      chk("t2_ptr", dut.rr_ptr, 0);
      step();
      chk("t2_idle", regwr, 0);

      // 3: write to x0 from src1
      drive(1, 5'd0, 32'h12345678);
      chk("t3_ready", in_ready[1], 1);
      step();
      in_valid = '0;
      chk("t3_buf", buf_valid, 3'b010);
      step();
      chk("t3_regwr", regwr, 0);
      chk("t3_buf_drained", buf_valid, 0);
      @(negedge clk);
      #1;
      chk("t3_rf0", rf[0], 0);
      step();

      // 4: freeze with all buffers full; rr_ptr is 2 after the src1 grant
      en = 1'b0;
      for (int s = 0; s < NREQ; s++) drive(s, 5'(10 + s), 32'hA0 + s);
      step();
      for (int c = 0; c < 4; c++) begin
         chk("t4_ready", in_ready, 0);
         chk("t4_regwr", regwr, 0);
         chk("t4_buf", buf_valid, 3'b111);
         step();
      end
      en       = 1'b1;
      in_valid = '0;
      expect_wr(5'd12, 32'hA2);
      expect_wr(5'd10, 32'hA0);
      expect_wr(5'd11, 32'hA1);
      step();
      chk("t4_first", rw, 12);
      step();
      step();
      step();
      chk("t4_drained", buf_valid, 0);
      chk("t4_q", exp_q.size(), 0);

      // 5: flush with two buffers full (nothing expected)
      en = 1'b0;
      drive(0, 5'd20, 32'hBAD0);
      drive(1, 5'd21, 32'hBAD1);
      step();
      in_valid = '0;
      chk("t5_buf", buf_valid, 3'b011);
      en    = 1'b1;
      flush = 1'b1;
      #1;
      chk("t5_ready", in_ready, 0);
      step();
      flush = 1'b0;
      chk("t5_buf_clr", buf_valid, 0);
      chk("t5_regwr", regwr, 0);
      for (int c = 0; c < 4; c++) step();
      chk("t5_rf20", rf[20], 0);
      chk("t5_rf21", rf[21], 0);

      // 6: reset between edges while a write is in flight
      for (int s = 0; s < NREQ; s++) drive(s, 5'(7 + s), 32'hC0 + s);
      step();
      in_valid = '0;
      @(posedge clk);
      #2;
      chk("t6_inflight", regwr, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_regwr", regwr, 0);
      chk("t6_rw", rw, 0);
      chk("t6_busW", busW, 0);
      chk("t6_buf", buf_valid, 0);
      #1;
      rst_n = 1'b1;
      step();
      for (int s = 0; s < NREQ; s++) begin
         drive(s, 5'(13 + s), 32'hE0 + s);
         expect_wr(5'(13 + s), 32'hE0 + s);
      end
      step();
      in_valid = '0;
      step();
      chk("t6_first", rw, 13);
      step();
      step();
      step();
      for (int r = 7; r <= 9; r++) chk("t6_dropped", rf[r], 0);
      chk("t6_rf15", rf[15], 32'hE2);
      chk("final_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
